// File: rtl/spi_master_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI master driver.
// Ports: sys_clk/rst (sync, active-low); req/req_mosi_data0/1 in, req_ack out;
//   resp_valid/resp_err/resp_data out; busy out;
//   drv_comm_start/drv_mosi_data out, drv_bus_ready/drv_miso_new_data/drv_miso_data in.
module spi_master_arbiter #(
  parameter int NUM_DATA_BITS = 16,
  parameter int START_TIMEOUT = 8
) (
  input  logic                     sys_clk,
  input  logic                     rst,
  input  logic [1:0]               req,
  input  logic [NUM_DATA_BITS-1:0] req_mosi_data0,
  input  logic [NUM_DATA_BITS-1:0] req_mosi_data1,
  output logic [1:0]               req_ack,
  output logic [1:0]               resp_valid,
  output logic                     resp_err,
  output logic [NUM_DATA_BITS-1:0] resp_data,
  output logic                     busy,
  output logic                     drv_comm_start,
  output logic [NUM_DATA_BITS-1:0] drv_mosi_data,
  input  logic                     drv_bus_ready,
  input  logic                     drv_miso_new_data,
  input  logic [NUM_DATA_BITS-1:0] drv_miso_data
);

  localparam int CW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t                   state;
  state_t                   next;
  logic                     sel;
  logic                     owner;
  logic                     last_owner;
  logic [CW-1:0]            cnt;
  logic                     tmo;
  logic                     err_q;
  logic [NUM_DATA_BITS-1:0] data_q;
  logic [NUM_DATA_BITS-1:0] mosi_q;

  // On a tie the requester that was not served last wins.
  assign sel = (&req) ? ~last_owner : req[1];
  assign tmo = (cnt == CW'(START_TIMEOUT - 1));

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next = state;
    unique case (state)
      IDLE: begin
        if (|req && drv_bus_ready) next = START;
      end
      START: next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!drv_bus_ready) next = WAIT_DONE;
        else if (tmo)       next = RESP;
      end
      WAIT_DONE: begin
        if (drv_bus_ready) next = RESP;
      end
      RESP:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      cnt        <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      mosi_q     <= '0;
    end else begin
      if (state == IDLE && next == START) begin
        owner  <= sel;
        mosi_q <= sel ? req_mosi_data1 : req_mosi_data0;
        err_q  <= 1'b0;
        data_q <= '0;
      end
      if (state == START) cnt <= '0;
      if (state == WAIT_BUSY) begin
        cnt <= cnt + CW'(1);
        if (drv_bus_ready && tmo) begin
          err_q  <= 1'b1;
          data_q <= '0;
        end
      end
      // Capture happens even on the completing cycle.
      if (state == WAIT_DONE && drv_miso_new_data) data_q <= drv_miso_data;
      if (next == RESP && state != RESP) last_owner <= owner;
    end
  end

  // Ack is combinational so the request sees it on the granting edge.
  always_comb begin
    req_ack        = '0;
    resp_valid     = '0;
    resp_err       = 1'b0;
    resp_data      = '0;
    drv_comm_start = 1'b0;
    busy           = (state != IDLE);
    unique case (state)
      IDLE: begin
        if (rst && next == START) req_ack[sel] = 1'b1;
      end
      START: drv_comm_start = 1'b1;
      RESP: begin
        resp_valid[owner] = 1'b1;
        resp_err          = err_q;
        resp_data         = data_q;
      end
      default: ;
    endcase
  end

  assign drv_mosi_data = mosi_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter with a behavioural SPI driver.
// Inputs change at negedge+1, the driver model at negedge, samples at negedge+2/3.
module tb_spi_master_arbiter;

  localparam int W = 16;

  logic         sys_clk;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] d0;
  logic [W-1:0] d1;
  logic [1:0]   req_ack;
  logic [1:0]   resp_valid;
  logic         resp_err;
  logic [W-1:0] resp_data;
  logic         busy;
  logic         drv_comm_start;
  logic [W-1:0] drv_mosi_data;
  logic         drv_bus_ready;
  logic         drv_miso_new_data;
  logic [W-1:0] drv_miso_data;

  spi_master_arbiter #(
    .NUM_DATA_BITS(W),
    .START_TIMEOUT(8)
  ) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .req              (req),
    .req_mosi_data0   (d0),
    .req_mosi_data1   (d1),
    .req_ack          (req_ack),
    .resp_valid       (resp_valid),
    .resp_err         (resp_err),
    .resp_data        (resp_data),
    .busy             (busy),
    .drv_comm_start   (drv_comm_start),
    .drv_mosi_data    (drv_mosi_data),
    .drv_bus_ready    (drv_bus_ready),
    .drv_miso_new_data(drv_miso_new_data),
    .drv_miso_data    (drv_miso_data)
  );

  typedef struct packed {
    logic [1:0]   rv;
    logic         err;
    logic [W-1:0] data;
  } resp_t;

  resp_t        sb[$];
  logic [W-1:0] mosi_q[$];
  logic [W-1:0] miso_q[$];

  int checks   = 0;
  int errors   = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  int resp_cyc = 0;
  bit stuck    = 0;
  bit same     = 0;
  bit nocap    = 0;
  bit hold     = 0;
  int lat      = 4;

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  initial forever begin
    @(posedge sys_clk);
    cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural SPI master driver.
  initial begin : drv
    int           cnt;
    int           ds;
    logic [W-1:0] w;
    drv_bus_ready     = 1'b1;
    drv_miso_new_data = 1'b0;
    drv_miso_data     = '0;
    cnt = 0;
    ds  = 0;
    w   = '0;
    forever begin
      @(negedge sys_clk);
      drv_miso_new_data = 1'b0;
      if (!rst) begin
        ds            = 0;
        drv_bus_ready = 1'b1;
      end else begin
        case (ds)
          0: begin
            drv_bus_ready = !hold;
            if (drv_comm_start) begin
              if (mosi_q.size() == 0)
                chk("mosi_q", 32'(mosi_q.size()), 32'd1);
              else
                chk("drv_mosi", 32'(drv_mosi_data), 32'(mosi_q.pop_front()));
              if (!stuck) begin
                w = (miso_q.size() > 0) ? miso_q.pop_front() : '0;
                drv_bus_ready = 1'b0;
                cnt = lat;
                ds  = 1;
              end
            end
          end
          1: begin
            cnt--;
            if (cnt == 1 && !same && !nocap) begin
              drv_miso_new_data = 1'b1;
              drv_miso_data     = ~w;
            end
            if (cnt == 0) begin
              if (!nocap) begin
                drv_miso_new_data = 1'b1;
                drv_miso_data     = w;
              end
              if (same) begin
                drv_bus_ready = 1'b1;
                ds = 0;
              end else begin
                ds = 2;
              end
            end
          end
          default: begin
            drv_bus_ready = 1'b1;
            ds = 0;
          end
        endcase
      end
    end
  end

  // Response monitor: pops the scoreboard on every resp_valid.
  initial begin : mon
    resp_t e;
    forever begin
      @(negedge sys_clk);
      #2;
      if (req_ack != 2'b00) begin
        ack_cnt++;
        chk("ack_onehot", 32'($onehot(req_ack)), 32'd1);
      end
      if (resp_valid != 2'b00) begin
        resp_cyc = cyc;
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(resp_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("resp_valid", 32'(resp_valid), 32'(e.rv));
          chk("resp_err", 32'(resp_err), 32'(e.err));
          chk("resp_data", 32'(resp_data), 32'(e.data));
        end
      end
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  task automatic expect_xfer(input logic [W-1:0] mosi, input logic [W-1:0] miso,
                             input logic [1:0] rv, input logic err,
                             input logic [W-1:0] data);
    mosi_q.push_back(mosi);
    miso_q.push_back(miso);
    sb.push_back('{rv: rv, err: err, data: data});
  endtask

  task automatic wait_ack(input logic [1:0] exp);
    int n;
    n = 0;
    #1;
    while (req_ack == 2'b00 && n < 60) begin
      @(negedge sys_clk);
      #3;
      n++;
    end
    chk("req_ack", 32'(req_ack), 32'(exp));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    step();
    while ((sb.size() != 0 || busy) && n < 200) begin
      step();
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_ack"}, 32'(req_ack), 32'd0);
    chk({tag, "_rv"}, 32'(resp_valid), 32'd0);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
    chk({tag, "_data"}, 32'(resp_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_start"}, 32'(drv_comm_start), 32'd0);
    chk({tag, "_mosi"}, 32'(drv_mosi_data), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int t;
    int k;
    rst = 1'b0;
    req = 2'b11;
    d0  = 16'hFFFF;
    d1  = 16'hFFFF;
    repeat (3) step();
    #1;
    chk_reset_outs("rst");
    step();
    req = 2'b00;
    step();
    rst = 1'b1;
    repeat (2) step();

    // Tie after reset: 0, 1, 0.
    d0 = 16'h37E1;
    d1 = 16'h2FA0;
    expect_xfer(16'h37E1, 16'h1111, 2'b01, 1'b0, 16'h1111);
    expect_xfer(16'h2FA0, 16'h2222, 2'b10, 1'b0, 16'h2222);
    expect_xfer(16'h37E1, 16'h3333, 2'b01, 1'b0, 16'h3333);
    req = 2'b11;
    wait_ack(2'b01);
    step();
    wait_ack(2'b10);
    step();
    wait_ack(2'b01);
    step();
    req = 2'b00;
    wait_idle();

    // Single transfer.
    d0 = 16'h0CF7;
    expect_xfer(16'h0CF7, 16'h4AC5, 2'b01, 1'b0, 16'h4AC5);
    req = 2'b01;
    wait_ack(2'b01);
    step();
    req = 2'b00;
    #1;
    chk("comm_start", 32'(drv_comm_start), 32'd1);
    chk("mosi_held", 32'(drv_mosi_data), 32'h0CF7);
    wait_idle();

    // Driver stuck ready: start timeout.
    stuck = 1'b1;
    d1 = 16'h5A5A;
    mosi_q.push_back(16'h5A5A);
    sb.push_back('{rv: 2'b10, err: 1'b1, data: '0});
    req = 2'b10;
    wait_ack(2'b10);
    t = cyc;
    step();
    req = 2'b00;
    wait_idle();
    chk("tmo_latency", 32'(resp_cyc - t), 32'd10);
    stuck = 1'b0;

    // Recovery after timeout.
    d0 = 16'h1234;
    expect_xfer(16'h1234, 16'hBEEF, 2'b01, 1'b0, 16'hBEEF);
    req = 2'b01;
    wait_ack(2'b01);
    step();
    req = 2'b00;
    wait_idle();

    // Same-cycle capture and completion.
    same = 1'b1;
    d1 = 16'h9999;
    expect_xfer(16'h9999, 16'h16FB, 2'b10, 1'b0, 16'h16FB);
    req = 2'b10;
    wait_ack(2'b10);
    t = cyc;
    step();
    req = 2'b00;
    wait_idle();
    chk("done_latency", 32'(resp_cyc - t), 32'd6);
    same = 1'b0;

    // Completion with no capture.
    nocap = 1'b1;
    d0 = 16'h7777;
    expect_xfer(16'h7777, 16'hAAAA, 2'b01, 1'b0, 16'h0000);
    req = 2'b01;
    wait_ack(2'b01);
    step();
    req = 2'b00;
    wait_idle();
    nocap = 1'b0;

    // Reset in the middle of WAIT_DONE.
    lat = 8;
    d0 = 16'h4444;
    mosi_q.push_back(16'h4444);
    miso_q.push_back(16'h5555);
    req = 2'b01;
    wait_ack(2'b01);
    step();
    req = 2'b00;
    repeat (4) step();
    chk("mid_busy", 32'({busy, drv_bus_ready}), 32'b10);
    rst = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk_reset_outs("mid");
    repeat (10) step();
    lat = 4;
    d0 = 16'h6666;
    expect_xfer(16'h6666, 16'h7070, 2'b01, 1'b0, 16'h7070);
    req = 2'b01;
    wait_ack(2'b01);
    step();
    req = 2'b00;
    wait_idle();

    // Request withdrawn while the driver is busy.
    hold = 1'b1;
    step();
    k = ack_cnt;
    req = 2'b01;
    repeat (2) begin
      step();
      chk("wd_busy", 32'(busy), 32'd0);
    end
    req = 2'b00;
    repeat (3) step();
    hold = 1'b0;
    repeat (3) step();
    chk("wd_noack", 32'(ack_cnt - k), 32'd0);
    chk("wd_idle", 32'(busy), 32'd0);
    chk("mosi_q_empty", 32'(mosi_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_master_arbiter.md
SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

Interface
REQ-001 SHALL have parameter NUM_DATA_BITS, default 16, SPI word width.
REQ-002 SHALL have parameter START_TIMEOUT, default 8, max cycles allowed for the driver to drop drv_bus_ready after a start.
REQ-003 SHALL have port sys_clk, input, 1, sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; one clock, synchronous, active-low.
REQ-005 SHALL have port req, input, 2, per-requester transfer request; level, held until acked.
REQ-006 SHALL have port req_mosi_data0, input, NUM_DATA_BITS, requester 0 word to transmit.
REQ-007 SHALL have port req_mosi_data1, input, NUM_DATA_BITS, requester 1 word to transmit.
REQ-008 SHALL have port req_ack, output, 2, one-cycle pulse; the request was accepted and its data latched.
REQ-009 SHALL have port resp_valid, output, 2, one-cycle pulse; the transfer for that requester completed.
REQ-010 SHALL have port resp_err, output, 1, qualifies resp_valid; 1 means driver start timeout.
REQ-011 SHALL have port resp_data, output, NUM_DATA_BITS, received MISO word; valid while resp_valid is nonzero.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port drv_comm_start, output, 1, start pulse to the SPI master driver.
REQ-014 SHALL have port drv_mosi_data, output, NUM_DATA_BITS, word to the driver; held stable from start to completion.
REQ-015 SHALL have port drv_bus_ready, input, 1, driver idle/ready.
REQ-016 SHALL have port drv_miso_new_data, input, 1, driver pulse marking drv_miso_data valid.
REQ-017 SHALL have port drv_miso_data, input, NUM_DATA_BITS, driver received word.

Function
REQ-018 SHALL implement the FSM states IDLE, START, WAIT_BUSY, WAIT_DONE and RESP.
REQ-019 IDLE SHALL go to START when any req bit is high and drv_bus_ready=1; otherwise it SHALL stay in IDLE.
REQ-020 On the IDLE->START edge, the arbiter SHALL pick the owner by round-robin, latch that requester's data into drv_mosi_data, and pulse req_ack[owner] for exactly 1 cycle.
REQ-021 Round-robin SHALL use pointer last_owner: if both request, the owner is the one not equal to last_owner; if only one requests, it is granted regardless.
REQ-022 last_owner SHALL update only on entry to RESP.
REQ-023 START SHALL assert drv_comm_start for exactly 1 cycle, then go to WAIT_BUSY.
REQ-024 WAIT_BUSY SHALL go to WAIT_DONE when drv_bus_ready=0, using a counter cleared on entry.
REQ-025 If the WAIT_BUSY counter reaches START_TIMEOUT cycles, WAIT_BUSY SHALL go to RESP with the error flag set and resp_data=0.
REQ-026 In WAIT_DONE, each drv_miso_new_data pulse SHALL capture drv_miso_data into the response register; the last capture wins.
REQ-027 WAIT_DONE SHALL go to RESP when drv_bus_ready=1.
REQ-028 If drv_bus_ready=1 and drv_miso_new_data=1 occur in the same cycle, the capture SHALL occur first, so that data is returned.
REQ-029 If WAIT_DONE ends with no capture, resp_data SHALL be 0 and resp_err SHALL be 0.
REQ-030 RESP SHALL drive resp_valid[owner]=1, resp_err=error flag and resp_data for exactly 1 cycle, then go to IDLE.
REQ-031 The earliest next grant SHALL be in the cycle after RESP, i.e. at least 1 IDLE cycle between transfers.
REQ-032 A req deasserted before it is acked SHALL be ignored; a req deasserted after ack SHALL NOT abort the transfer.
REQ-033 Only one req_ack bit and one resp_valid bit SHALL ever be high at a time.
REQ-034 Latency SHALL be ack-to-drv_comm_start = 1 cycle, and drv_bus_ready rise in WAIT_DONE to resp_valid = 1 cycle.

Reset
REQ-035 While rst=0 at a sys_clk edge, the block SHALL enter IDLE and drive req_ack=0, resp_valid=0, resp_err=0, resp_data=0, busy=0, drv_comm_start=0, drv_mosi_data=0.
REQ-036 Reset SHALL clear last_owner to 1, so requester 0 wins the first tie, and clear the counter.
REQ-037 Reset asserted mid-transfer SHALL abandon it with no resp_valid; the driver is reset by the same rst.

Verification
REQ-038 Single transfer: req=01, req_mosi_data0=16'h0CF7, driver model returns 16'h4AC5 -> req_ack=01 then drv_comm_start pulse, drv_mosi_data=16'h0CF7, then resp_valid=01, resp_data=16'h4AC5, resp_err=0.
REQ-039 Tie after reset: req=11 held, data0=16'h37E1, data1=16'h2FA0 -> first grant to 0, second to 1, third to 0; responses route to matching resp_valid bits.
REQ-040 Driver stuck ready (drv_bus_ready never drops): req=10 -> after 8 WAIT_BUSY cycles, resp_valid=10, resp_err=1, resp_data=0; next request is served normally.
REQ-041 Same-cycle completion: drv_miso_new_data and drv_bus_ready rise together carrying 16'h16FB -> resp_data=16'h16FB.
REQ-042 Reset mid-WAIT_DONE: rst=0 for 1 cycle -> all outputs at reset values next cycle, no resp_valid, then a new req=01 is granted.
REQ-043 Request withdrawn: req=01 pulsed while drv_bus_ready=0, then dropped -> no req_ack, busy stays 0.
